if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/riscv_pkg.sv | 17 +
 rtl/if_fetch_unit_if.sv | 23 ++
 rtl/if_perf_ctr.sv | 34 +++
 rtl/if_fetch_unit.sv | 131 +++++++++++++
 tb/tb_if_fetch_unit.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: NOP encoding, PC step and fetch FSM states.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [31:0] INSTR_STEP = 32'd4;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        KILL = 2'd1,
        HELD = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read port: master = fetch unit, slave = memory.
interface if_fetch_unit_if;

    logic        imem_read;
    logic [31:0] imem_addr;
    logic [31:0] imem_readdata;
    logic        imem_busywait;

    modport master (
        output imem_read,
        output imem_addr,
        input  imem_readdata,
        input  imem_busywait
    );

    modport slave (
        input  imem_read,
        input  imem_addr,
        output imem_readdata,
        output imem_busywait
    );

endinterface

// File: rtl/if_perf_ctr.sv
// Fetch performance counters (delivered instructions, memory wait cycles); wrap at 2^32.
module if_perf_ctr (
    input  logic        clk,
    input  logic        reset,
    input  logic        deliver,
    input  logic        imem_wait,
    output logic [31:0] fetch_count,
    output logic [31:0] imem_wait_cycles
);

    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] wait_cycles_q, wait_cycles_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        wait_cycles_d = wait_cycles_q;
        if (deliver)   fetch_count_d = fetch_count_q + 32'd1;
        if (imem_wait) wait_cycles_d = wait_cycles_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count_q <= 32'd0;
            wait_cycles_q <= 32'd0;
        end else begin
            fetch_count_q <= fetch_count_d;
            wait_cycles_q <= wait_cycles_d;
        end
    end

    assign fetch_count      = fetch_count_q;
    assign imem_wait_cycles = wait_cycles_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC, REQ/KILL/HELD fetch FSM and IF/ID handshake.
// Optional macro IF_FETCH_PERF_EN adds fetch_count / imem_wait_cycles outputs.
module if_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [31:0]           branch_target,
    if_fetch_unit_if.master       imem,
    output logic [31:0]           instruction_out,
    output logic [31:0]           PC_out,
    output logic                  busywait,
    output logic                  NOP_sel
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]           fetch_count,
    output logic [31:0]           imem_wait_cycles
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  hold_q, hold_d;
    logic [31:0]  target_q, target_d;
    logic         read_req;
    logic         complete;
    logic [31:0]  br_tgt;

    // Outputs are gated by the live reset level so reset values appear immediately.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        hold_d          = hold_q;
        target_d        = target_q;
        read_req        = 1'b0;
        complete        = 1'b0;
        busywait        = 1'b1;
        NOP_sel         = 1'b0;
        instruction_out = NOP_INSTR;
        br_tgt          = align_word(branch_target);

        if (reset) begin
            read_req = (state_q != HELD);
            complete = read_req && !imem.imem_busywait;

            if (branch_taken) begin
                busywait = 1'b0;
                NOP_sel  = 1'b1;
                if (complete || state_q == HELD) begin
                    pc_d    = br_tgt;
                    hold_d  = NOP_INSTR;
                    state_d = REQ;
                end else begin
                    // Response still in flight: remember where to go once it drains.
                    target_d = br_tgt;
                    state_d  = KILL;
                end
            end else begin
                unique case (state_q)
                    REQ: begin
                        if (complete) begin
                            if (stall) begin
                                hold_d  = imem.imem_readdata;
                                state_d = HELD;
                            end else begin
                                busywait        = 1'b0;
                                instruction_out = imem.imem_readdata;
                                pc_d            = pc_q + INSTR_STEP;
                            end
                        end
                    end
                    KILL: begin
                        if (complete) begin
                            pc_d    = target_q;
                            state_d = REQ;
                        end
                    end
                    HELD: begin
                        if (!stall) begin
                            busywait        = 1'b0;
                            instruction_out = hold_q;
                            pc_d            = pc_q + INSTR_STEP;
                            state_d         = REQ;
                        end
                    end
                    default: state_d = REQ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= REQ;
            pc_q     <= RESET_PC;
            hold_q   <= NOP_INSTR;
            target_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            hold_q   <= hold_d;
            target_q <= target_d;
        end
    end

    assign imem.imem_read = read_req;
    assign imem.imem_addr = pc_q;
    assign PC_out         = pc_q;

`ifdef IF_FETCH_PERF_EN
    logic deliver;
    logic imem_wait;

    assign deliver   = !busywait && !NOP_sel;
    assign imem_wait = read_req && imem.imem_busywait;

    if_perf_ctr u_perf_ctr (
        .clk              (clk),
        .reset            (reset),
        .deliver          (deliver),
        .imem_wait        (imem_wait),
        .fetch_count      (fetch_count),
        .imem_wait_cycles (imem_wait_cycles)
    );
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: vector table through a scoreboard queue plus reset corner sequences.
module tb_if_fetch_unit;
    import riscv_pkg::*;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        mbusy;
        logic        e_read;
        logic [31:0] e_addr;
        logic        e_bw;
        logic        e_nop;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        mbusy;
    logic [31:0] instruction_out;
    logic [31:0] PC_out;
    logic        busywait;
    logic        NOP_sel;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] imem_wait_cycles;
`endif

    vec_t        vecs[$];
    vec_t        sb[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] exp_fetch = 32'd0;
    logic [31:0] exp_wait  = 32'd0;

    if_fetch_unit_if bus ();

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:24] ^ 8'hA5, a[23:0]};
    endfunction

    // Memory model: data is only valid on a completing read, garbage otherwise.
    assign bus.imem_readdata = (bus.imem_read && !bus.imem_busywait) ? mem_word(bus.imem_addr) : 32'hDEAD_BEEF;
    assign bus.imem_busywait = mbusy;

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .imem             (bus),
        .instruction_out  (instruction_out),
        .PC_out           (PC_out),
        .busywait         (busywait),
        .NOP_sel          (NOP_sel)
`ifdef IF_FETCH_PERF_EN
        ,
        .fetch_count      (fetch_count),
        .imem_wait_cycles (imem_wait_cycles)
`endif
    );

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic b, input logic [31:0] t, input logic mb,
                       input logic er, input logic [31:0] ea, input logic ebw, input logic en);
        vec_t v;
        v.stall = s; v.br = b; v.tgt = t; v.mbusy = mb;
        v.e_read = er; v.e_addr = ea; v.e_bw = ebw; v.e_nop = en;
        vecs.push_back(v);
    endtask

    task automatic z(input logic [31:0] a);
        add(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, a, 1'b0, 1'b0);
    endtask

    task automatic check_out();
        vec_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
        end else begin
            e = sb.pop_front();
            chk1 ("imem_read", bus.imem_read, e.e_read);
            chk32("imem_addr", bus.imem_addr, e.e_addr);
            chk32("PC_out",    PC_out,        e.e_addr);
            chk1 ("busywait",  busywait,      e.e_bw);
            chk1 ("NOP_sel",   NOP_sel,       e.e_nop);
            if (!e.e_bw && !e.e_nop) begin
                chk32("instruction_out", instruction_out, mem_word(e.e_addr));
                exp_fetch++;
            end
            if (e.e_read && e.mbusy) exp_wait++;
        end
    endtask

    task automatic step(input vec_t v);
        stall         = v.stall;
        branch_taken  = v.br;
        branch_target = v.tgt;
        mbusy         = v.mbusy;
        sb.push_back(v);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk1 ({tag, "_imem_read"}, bus.imem_read,   1'b0);
        chk32({tag, "_imem_addr"}, bus.imem_addr,   32'h0);
        chk32({tag, "_PC_out"},    PC_out,          32'h0);
        chk1 ({tag, "_busywait"},  busywait,        1'b1);
        chk1 ({tag, "_NOP_sel"},   NOP_sel,         1'b0);
        chk32({tag, "_instr"},     instruction_out, NOP_INSTR);
`ifdef IF_FETCH_PERF_EN
        chk32({tag, "_fetch_count"}, fetch_count,      32'd0);
        chk32({tag, "_wait_cycles"}, imem_wait_cycles, 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Sequential fetch with zero-wait memory.
        z(32'h0); z(32'h4); z(32'h8); z(32'hC);
        // Three wait cycles at 0x10.
        for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h10, 1'b1, 1'b0);
        z(32'h10);
        z(32'h14); z(32'h18); z(32'h1C);
        // Stall in the completion cycle of 0x20, held for two cycles.
        add(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'h20, 1'b1, 1'b0);
        add(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'h20, 1'b1, 1'b0);
        add(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'h20, 1'b0, 1'b0);
        z(32'h24);
        for (int a = 32'h28; a <= 32'h3C; a += 4) z(32'(a));
        // Branch to 0x103 during a wait at 0x40: KILL then 0x100.
        add(1'b0, 1'b0, 32'd0,       1'b1, 1'b1, 32'h40, 1'b1, 1'b0);
        add(1'b0, 1'b1, 32'h103,     1'b1, 1'b1, 32'h40, 1'b0, 1'b1);
        add(1'b0, 1'b0, 32'd0,       1'b0, 1'b1, 32'h40, 1'b1, 1'b0);
        z(32'h100);
        // Branch while HELD, with stall still high.
        add(1'b1, 1'b0, 32'd0,       1'b0, 1'b1, 32'h104, 1'b1, 1'b0);
        add(1'b1, 1'b1, 32'h200,     1'b0, 1'b0, 32'h104, 1'b0, 1'b1);
        z(32'h200);
        // Branch on a completing cycle, then PC wrap past 0xFFFFFFFC.
        add(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h204, 1'b0, 1'b1);
        z(32'hFFFF_FFFC);
        z(32'h0);
        // Second branch in KILL overwrites the latched target.
        add(1'b0, 1'b1, 32'h300,     1'b1, 1'b1, 32'h4, 1'b0, 1'b1);
        add(1'b0, 1'b1, 32'h401,     1'b1, 1'b1, 32'h4, 1'b0, 1'b1);
        add(1'b0, 1'b0, 32'd0,       1'b0, 1'b1, 32'h4, 1'b1, 1'b0);
        z(32'h400);
        // Stall during a wait cycle without completion.
        add(1'b1, 1'b0, 32'd0,       1'b1, 1'b1, 32'h404, 1'b1, 1'b0);
        z(32'h404);

        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0; mbusy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;

        foreach (vecs[i]) step(vecs[i]);

`ifdef IF_FETCH_PERF_EN
        chk32("fetch_count",      fetch_count,      exp_fetch);
        chk32("imem_wait_cycles", imem_wait_cycles, exp_wait);
`endif

        // Reset pulse in the middle of a wait at 0x408.
        stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0; mbusy = 1'b1;
        @(negedge clk);
        chk1 ("prewait_read", bus.imem_read, 1'b1);
        chk32("prewait_addr", bus.imem_addr, 32'h408);
        chk1 ("prewait_bw",   busywait,      1'b1);
        reset = 1'b0;
        #1;
        check_reset_vals("midreset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        mbusy = 1'b0;
        @(negedge clk);
        chk1 ("restart_read",  bus.imem_read,   1'b1);
        chk32("restart_addr",  bus.imem_addr,   32'h0);
        chk1 ("restart_bw",    busywait,        1'b0);
        chk32("restart_instr", instruction_out, mem_word(32'h0));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk32("restart_next_addr", bus.imem_addr, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
